window_serializer: RTL
======================

WINDOW_SERIALIZER -- requirements
Module: window_serializer

Interface
REQ-001: Parameter WINDOW_WIDTH, default 1152, SHALL be the bit width of one detection window.
REQ-002: Parameter LEVELS, default 15, SHALL be the number of pyramid-level window streams consumed (valid range 1..16).
REQ-003: Parameter BEAT_WIDTH, default 64, SHALL be the output beat width; WINDOW_WIDTH SHALL be an integer multiple of BEAT_WIDTH, and BEATS = WINDOW_WIDTH/BEAT_WIDTH.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: detection_window  input  WINDOW_WIDTH*LEVELS  SHALL carry level i's window in bits [i*WINDOW_WIDTH +: WINDOW_WIDTH].
REQ-007: window_valid  input  LEVELS  SHALL be per-level window valid.
REQ-008: window_ready  output  LEVELS  SHALL be per-level window ready, at most one bit set.
REQ-009: beat_data  output  BEAT_WIDTH  SHALL be the current output beat.
REQ-010: beat_level  output  4  SHALL be the level index of the window being sent.
REQ-011: beat_last  output  1  SHALL mark the final beat of a window.
REQ-012: beat_valid  output  1; beat_ready  input  1  SHALL form the output handshake.
REQ-013: busy  output  1  SHALL be high whenever the FSM is in SEND.

Function
REQ-014: FSM SHALL have two states: IDLE and SEND.
REQ-015: In IDLE, grant g SHALL be the first index with window_valid set, searching from rr_ptr upward and wrapping at LEVELS-1 to 0.
REQ-016: In IDLE, window_ready SHALL be one-hot at g when any window_valid bit is set, else all zero; window_ready is combinational from window_valid, rr_ptr and state.
REQ-017: In SEND, window_ready SHALL be all zero.
REQ-018: On an IDLE cycle with a grant, the block SHALL capture detection_window slice g into the window register, set beat_level=g, beat counter=0, rr_ptr = (g==LEVELS-1) ? 0 : g+1, and enter SEND.
REQ-019: In SEND, beat_valid SHALL be 1 and beat_data SHALL equal the low BEAT_WIDTH bits of the window register; beat 0 SHALL be window bits [BEAT_WIDTH-1:0].
REQ-020: On beat_valid && beat_ready, the window register SHALL shift right by BEAT_WIDTH and the beat counter SHALL increment.
REQ-021: beat_last SHALL be 1 exactly when in SEND and beat counter == BEATS-1.
REQ-022: On the handshake of the beat_last beat, the FSM SHALL return to IDLE; no new window SHALL be accepted in that same cycle (one idle cycle minimum between windows).
REQ-023: While beat_valid && !beat_ready, beat_data, beat_level and beat_last SHALL hold stable.
REQ-024: First beat_valid SHALL assert the cycle after window capture (latency 1); a window completes in BEATS cycles at beat_ready=1.
REQ-025: In IDLE, beat_valid and beat_last SHALL be 0; beat_data and beat_level SHALL hold their last values.
REQ-026: Changes on window_valid during SEND SHALL have no effect on state.
REQ-027: BEATS==1 SHALL be supported: beat_last SHALL be high on the sole beat.

Reset
REQ-028: While rst=0, state SHALL be IDLE, rr_ptr=0, beat counter=0, window register=0, and beat_valid, beat_last, beat_level, beat_data, busy, window_ready SHALL all be 0.
REQ-029: Reset asserted mid-SEND SHALL abort the window immediately; after release, operation SHALL resume from IDLE with rr_ptr=0 and no partial beats emitted.

Verification (bench parameters: WINDOW_WIDTH=256, BEAT_WIDTH=64, LEVELS=4, BEATS=4)
REQ-030: Single window: window_valid=4'b0100, slice 2 = 0x4444..._3333..._2222..._1111... (64-bit words), beat_ready=1 -> window_ready=4'b0100 for one cycle; next 4 cycles beat_data=0x1111..,0x2222..,0x3333..,0x4444.., beat_level=2, beat_last only on 4th beat.
REQ-031: Round-robin: window_valid=4'b1111 held constant -> grants in order 0,1,2,3,0; each window 4 beats plus 1 idle cycle.
REQ-032: Backpressure: beat_ready toggling 1,0,0,1,... during SEND -> beat_data/beat_level/beat_last stable across stalled cycles; exactly 4 beats transferred, values in order.
REQ-033: Wrap: rr_ptr=3 after granting level 2, window_valid=4'b0011 -> grant level 0, then level 1.
REQ-034: Reset mid-SEND: rst=0 after 2nd beat -> all outputs 0 asynchronously; after release with window_valid=4'b1000 -> grant 3, full 4-beat window from beat 0.
REQ-035: No request: window_valid=0 for 10 cycles -> window_ready=0, beat_valid=0, busy=0 throughout.

Source files
------------

// File: rtl/window_serializer.sv
// Purpose: round-robin arbiter over LEVELS window streams; serializes one
//          WINDOW_WIDTH window into BEATS beats of BEAT_WIDTH, LSB beat first.
// Latency: first beat valid the cycle after capture; BEATS cycles per window
//          at full rate, plus at least one idle cycle between windows.
// Backpressure: beat_ready low stalls the current beat with data/level/last
//          held; window_ready stays low while a window is being sent.
// Ports:
//   clk, rst              - clock, async active-low reset
//   detection_window      - LEVELS packed windows, level i at [i*WINDOW_WIDTH +: WINDOW_WIDTH]
//   window_valid/_ready   - per-level request / one-hot grant
//   beat_data/_level/_last/_valid, beat_ready - output beat stream
//   busy                  - high while a window is being sent
module window_serializer #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int LEVELS       = 15,
  parameter int BEAT_WIDTH   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WINDOW_WIDTH*LEVELS-1:0] detection_window,
  input  logic [LEVELS-1:0]              window_valid,
  output logic [LEVELS-1:0]              window_ready,
  output logic [BEAT_WIDTH-1:0]          beat_data,
  output logic [3:0]                     beat_level,
  output logic                           beat_last,
  output logic                           beat_valid,
  input  logic                           beat_ready,
  output logic                           busy
);

  localparam int BEATS = WINDOW_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [3:0]       LAST_LVL = 4'(LEVELS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WINDOW_WIDTH-1:0] win_q, win_d;
  logic [3:0]              level_q, level_d;

  logic [3:0]              grant;
  logic                    grant_vld;

  // Round-robin search. Both loops run high-to-low so the last hit wins:
  // the first loop finds the lowest valid index overall (the wrapped case),
  // the second overrides it with the lowest valid index at or above rr_ptr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = LEVELS - 1; i >= 0; i--) begin
      if (window_valid[i]) begin
        grant     = 4'(i);
        grant_vld = 1'b1;
      end
    end
    for (int i = LEVELS - 1; i >= 0; i--) begin
      if (window_valid[i] && (4'(i) >= rr_ptr_q)) begin
        grant = 4'(i);
      end
    end
  end

  // Ready is qualified by rst so the grant cannot leak out while reset is held.
  always_comb begin
    window_ready = '0;
    for (int i = 0; i < LEVELS; i++) begin
      window_ready[i] = rst && (state_q == IDLE) && grant_vld && (grant == 4'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    level_d  = level_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          for (int i = 0; i < LEVELS; i++) begin
            if (grant == 4'(i)) begin
              win_d = detection_window[i*WINDOW_WIDTH +: WINDOW_WIDTH];
            end
          end
          level_d  = grant;
          cnt_d    = '0;
          rr_ptr_d = (grant == LAST_LVL) ? 4'd0 : grant + 4'd1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (beat_ready) begin
          if (cnt_q == LAST_CNT) begin
            // The last beat is not shifted out so beat_data keeps showing it in IDLE.
            state_d = IDLE;
          end else begin
            win_d = win_q >> BEAT_WIDTH;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      level_q  <= level_d;
    end
  end

  assign beat_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign beat_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign beat_data  = win_q[BEAT_WIDTH-1:0];
  assign beat_level = level_q;

endmodule
